// File: rtl/fp_div_scheduler.sv
// Round-robin scheduler sharing one combinational FP divider among requesters.
// Ports: clk/rst, req_* (valid/ready, packed operands), rsp_* (result, id, flags), div_* (shared divider), busy.
module fp_div_scheduler #(
  parameter int N_REQ  = 2,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_op_a,
  input  logic [32*N_REQ-1:0]  req_op_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [31:0]          rsp_res,
  output logic [2:0]           rsp_flags,
  output logic                 div_en,
  output logic [31:0]          div_op_a,
  output logic [31:0]          div_op_b,
  input  logic [31:0]          div_res,
  input  logic                 div_dbz,
  input  logic                 div_ovf,
  input  logic                 div_unf,
  output logic                 busy
);

  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [1:0]    ptr;
  logic [1:0]    id_q;
  logic [CW-1:0] cnt;
  logic [31:0]   op_a_q, op_b_q;

  logic          found;
  logic          accept;
  logic [1:0]    gnt;
  logic [1:0]    nxt_ptr;
  logic [31:0]   sel_a, sel_b;
  logic [31:0]   cap_res;
  logic [2:0]    cap_flags;
  logic          za, zb, sgn;

  // The divider's own div-by-zero flag is superseded by the zero checks below.
  logic          unused_dbz;
  assign unused_dbz = div_dbz;

  assign div_op_a = op_a_q;
  assign div_op_b = op_b_q;

  // Rotating priority search starting at ptr; loops unroll to constant indices.
  always_comb begin
    found = 1'b0;
    gnt   = ptr;
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req_valid[i] &&
            (i == (int'(ptr) + k) % N_REQ)) begin
          found = 1'b1;
          gnt   = 2'(i);
          sel_a = req_op_a[32*i +: 32];
          sel_b = req_op_b[32*i +: 32];
        end
      end
    end
  end

  assign nxt_ptr = (gnt == 2'(N_REQ - 1)) ? 2'd0 : gnt + 2'd1;

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        accept = found && !rst;
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        if (cnt == '0) state_d = RESPOND;
      end
      RESPOND: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = accept && (gnt == 2'(i));
    end
  end

  // All-32-bit zero tests: -0.0 is not treated as zero.
  always_comb begin
    za  = (op_a_q == 32'h0);
    zb  = (op_b_q == 32'h0);
    sgn = op_a_q[31] ^ op_b_q[31];
    cap_res   = div_res;
    cap_flags = {1'b0, div_ovf, div_unf};
    if (za) begin
      cap_res   = 32'h0;
      cap_flags = 3'b000;
    end else if (zb) begin
      cap_res   = {sgn, 8'hFF, 23'h0};
      cap_flags = 3'b100;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      id_q      <= '0;
      cnt       <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      div_en    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_res   <= '0;
      rsp_flags <= '0;
      busy      <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d != IDLE);
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_a_q <= sel_a;
            op_b_q <= sel_b;
            id_q   <= gnt;
            ptr    <= nxt_ptr;
            cnt    <= CW'(SETTLE - 1);
            div_en <= 1'b1;
          end
        end
        ISSUE: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            div_en    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_res   <= cap_res;
            rsp_flags <= cap_flags;
          end
        end
        RESPOND: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_scheduler.sv
// Directed self-checking bench for fp_div_scheduler (N_REQ=2, SETTLE=2).
// Divider is a stub driven directly by the bench.
module tb_fp_div_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_op_a;
  logic [63:0] req_op_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_res;
  logic [2:0]  rsp_flags;
  logic        div_en;
  logic [31:0] div_op_a;
  logic [31:0] div_op_b;
  logic [31:0] div_res;
  logic        div_dbz;
  logic        div_ovf;
  logic        div_unf;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fp_div_scheduler #(.N_REQ(2), .SETTLE(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
    .div_en(div_en), .div_op_a(div_op_a), .div_op_b(div_op_b),
    .div_res(div_res), .div_dbz(div_dbz),
    .div_ovf(div_ovf), .div_unf(div_unf),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input int idx,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] stub_res,
                       input logic [2:0] stub_fl,
                       input logic [31:0] exp_res,
                       input logic [2:0] exp_fl);
    int n;
    logic [1:0] oh;
    div_res = stub_res;
    {div_dbz, div_ovf, div_unf} = stub_fl;
    rsp_ready = 1'b1;
    oh = (idx == 0) ? 2'b01 : 2'b10;
    if (idx == 0) begin
      req_op_a[31:0] = a;
      req_op_b[31:0] = b;
    end else begin
      req_op_a[63:32] = a;
      req_op_b[63:32] = b;
    end
    req_valid = oh;
    #1;
    chk({tag, "_rdy"}, 32'(req_ready), 32'(oh));
    tick();
    req_valid = 2'b00;
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(idx));
    chk({tag, "_res"}, rsp_res, exp_res);
    chk({tag, "_flags"}, 32'(rsp_flags), 32'(exp_fl));
    tick();
  endtask

  int          gcyc[$];
  logic [1:0]  gid[$];
  int          exp_cyc[4] = '{0, 4, 8, 12};
  logic [1:0]  exp_gid[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0] hold_res;
  int          n;
  logic        seen;

  initial begin
    rst = 1'b1;
    req_valid = 2'b11;
    req_op_a = 64'h0;
    req_op_b = 64'h0;
    rsp_ready = 1'b0;
    div_res = 32'h0;
    {div_dbz, div_ovf, div_unf} = 3'b000;

    // Reset behaviour
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_div_en", 32'(div_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_res", rsp_res, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_div_op_a", div_op_a, 32'd0);
    chk("rst_div_op_b", div_op_b, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'b01);

    // Single request with latency checks
    req_valid = 2'b01;
    req_op_a[31:0] = 32'h41200000;
    req_op_b[31:0] = 32'h40A00000;
    div_res = 32'h40000000;
    rsp_ready = 1'b1;
    #1;
    chk("single_rdy", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    chk("single_en_t1", 32'(div_en), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_opa", div_op_a, 32'h41200000);
    chk("single_opb", div_op_b, 32'h40A00000);
    chk("single_nvalid_t1", 32'(rsp_valid), 32'd0);
    tick();
    chk("single_en_t2", 32'(div_en), 32'd1);
    chk("single_nvalid_t2", 32'(rsp_valid), 32'd0);
    tick();
    chk("single_valid_t3", 32'(rsp_valid), 32'd1);
    chk("single_en_t3", 32'(div_en), 32'd0);
    chk("single_id", 32'(rsp_id), 32'd0);
    chk("single_res", rsp_res, 32'h40000000);
    chk("single_flags", 32'(rsp_flags), 32'd0);
    chk("single_hold_opa", div_op_a, 32'h41200000);
    tick();
    chk("single_done_valid", 32'(rsp_valid), 32'd0);
    chk("single_done_busy", 32'(busy), 32'd0);

    // Fairness from ptr=0
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    req_valid = 2'b11;
    req_op_a = {32'h40400000, 32'h3F800000};
    req_op_b = {32'h3F800000, 32'h3F800000};
    for (int i = 0; i <= 12; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        gcyc.push_back(i);
        gid.push_back(req_ready);
      end
      tick();
    end
    req_valid = 2'b00;
    chk("fair_count", 32'(gcyc.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < gcyc.size()) begin
        chk($sformatf("fair_cyc%0d", j), 32'(gcyc[j]), 32'(exp_cyc[j]));
        chk($sformatf("fair_id%0d", j), 32'(gid[j]), 32'(exp_gid[j]));
      end
    end
    tick();
    tick();
    tick();

    // Zero-operand sanitising and flag pass-through
    do_op("dbz_pos", 0, 32'h40000000, 32'h0, 32'h12345678, 3'b100,
          32'h7F800000, 3'b100);
    do_op("dbz_neg", 1, 32'hC0000000, 32'h0, 32'h12345678, 3'b010,
          32'hFF800000, 3'b100);
    do_op("zero_zero", 0, 32'h0, 32'h0, 32'h12345678, 3'b111,
          32'h0, 3'b000);
    do_op("zero_num", 1, 32'h0, 32'h40000000, 32'h55555555, 3'b011,
          32'h0, 3'b000);
    do_op("ovf", 0, 32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b110,
          32'h7F800000, 3'b010);
    do_op("unf", 1, 32'h00800000, 32'h7F000000, 32'h00000000, 3'b001,
          32'h00000000, 3'b001);
    do_op("negzero_a", 0, 32'h80000000, 32'h3F800000, 32'h80000000, 3'b000,
          32'h80000000, 3'b000);
    do_op("negzero_b", 1, 32'h3F800000, 32'h80000000, 32'hFF800000, 3'b100,
          32'hFF800000, 3'b000);

    // Backpressure
    rsp_ready = 1'b0;
    div_res = 32'h3F000000;
    {div_dbz, div_ovf, div_unf} = 3'b100;
    req_op_a[31:0] = 32'h3F800000;
    req_op_b[31:0] = 32'h40000000;
    req_valid = 2'b01;
    #1;
    chk("bp_rdy0", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b10;
    req_op_a[63:32] = 32'h40400000;
    req_op_b[63:32] = 32'h3F800000;
    #1;
    chk("bp_wait_t1", 32'(req_ready), 32'd0);
    tick();
    chk("bp_wait_t2", 32'(req_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_res%0d", i), rsp_res, 32'h3F000000);
      chk($sformatf("bp_id%0d", i), 32'(rsp_id), 32'd0);
      chk($sformatf("bp_flags%0d", i), 32'(rsp_flags), 32'd0);
      chk($sformatf("bp_rdy%0d", i), 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_req1_rdy", 32'(req_ready), 32'b10);
    tick();
    req_valid = 2'b00;
    chk("bp_req1_busy", 32'(busy), 32'd1);
    chk("bp_req1_en", 32'(div_en), 32'd1);
    chk("bp_req1_opa", div_op_a, 32'h40400000);

    // Reset during ISSUE
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_en", 32'(div_en), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
